// File: rtl/interpreter.sv
// -----------------------------------------------------------------------------
// interpreter -- instruction decode stage
//
// Splits a 16-bit instruction word into its fields, evaluates the condition
// code against the status flags sampled with the instruction, and builds a
// one-hot opcode vector. Every output is registered, so each result appears
// one cycle after the instruction is accepted.
//
// Instruction layout:
//   [15:14] cond  [13:10] op_code  [9:7] dest_reg  [6:4] src_reg_1
//   [3:1] src_reg_2  [0] shift
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   inst        instruction word
//   inst_valid  inst holds a new instruction this cycle
//   flag_z      zero status flag
//   flag_n      negative status flag
//   cond, op_code, dest_reg, src_reg_1, src_reg_2, shift
//               registered instruction fields
//   op_onehot   1 << op_code
//   cond_pass   condition satisfied by the sampled flags
//   out_valid   outputs hold a newly decoded instruction this cycle
//   illegal     reserved opcode (15) decoded
//
// Build option:
//   INTERPRETER_ILLEGAL_CHECK_EN  when defined, opcode 15 raises illegal and
//                                 forces cond_pass low. When undefined,
//                                 illegal is tied low and opcode 15 decodes
//                                 like any other opcode.
// -----------------------------------------------------------------------------
module interpreter (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] inst,
   input  logic        inst_valid,
   input  logic        flag_z,
   input  logic        flag_n,
   output logic [1:0]  cond,
   output logic [3:0]  op_code,
   output logic [2:0]  dest_reg,
   output logic [2:0]  src_reg_1,
   output logic [2:0]  src_reg_2,
   output logic        shift,
   output logic [15:0] op_onehot,
   output logic        cond_pass,
   output logic        out_valid,
   output logic        illegal
);

   logic       cond_ok;
   logic       illegal_d;
   logic [1:0] inst_cond;
   logic [3:0] inst_op;

   assign inst_cond = inst[15:14];
   assign inst_op   = inst[13:10];

   always_comb begin
      cond_ok = 1'b0;
      case (inst_cond)
         2'd0:    cond_ok = 1'b1;
         2'd1:    cond_ok = flag_z;
         2'd2:    cond_ok = ~flag_z;
         default: cond_ok = flag_n;
      endcase
   end

`ifdef INTERPRETER_ILLEGAL_CHECK_EN
   assign illegal_d = &inst_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal <= 1'b0;
      end else if (inst_valid) begin
         illegal <= illegal_d;
      end
   end
`else
   assign illegal_d = 1'b0;
   assign illegal   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cond      <= 2'd0;
         op_code   <= 4'd0;
         dest_reg  <= 3'd0;
         src_reg_1 <= 3'd0;
         src_reg_2 <= 3'd0;
         shift     <= 1'b0;
         // Consistent with op_code = 0.
         op_onehot <= 16'h0001;
         cond_pass <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= inst_valid;
         if (inst_valid) begin
            cond      <= inst_cond;
            op_code   <= inst_op;
            dest_reg  <= inst[9:7];
            src_reg_1 <= inst[6:4];
            src_reg_2 <= inst[3:1];
            shift     <= inst[0];
            op_onehot <= 16'h0001 << inst_op;
            // A reserved opcode never executes, whatever the flags say.
            cond_pass <= cond_ok & ~illegal_d;
         end
      end
   end

endmodule

// File: tb/tb_interpreter.sv
module tb_interpreter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] inst;
   logic        inst_valid;
   logic        flag_z;
   logic        flag_n;
   logic [1:0]  cond;
   logic [3:0]  op_code;
   logic [2:0]  dest_reg;
   logic [2:0]  src_reg_1;
   logic [2:0]  src_reg_2;
   logic        shift;
   logic [15:0] op_onehot;
   logic        cond_pass;
   logic        out_valid;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef INTERPRETER_ILLEGAL_CHECK_EN
   localparam bit ILLEGAL_EN = 1'b1;
`else
   localparam bit ILLEGAL_EN = 1'b0;
`endif

   typedef struct {
      int c;
      int op;
      int dst;
      int s1;
      int s2;
      int sh;
      int oh;
      int pass;
      int ill;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;

   interpreter dut (
      .clk        (clk),
      .rst        (rst),
      .inst       (inst),
      .inst_valid (inst_valid),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .cond       (cond),
      .op_code    (op_code),
      .dest_reg   (dest_reg),
      .src_reg_1  (src_reg_1),
      .src_reg_2  (src_reg_2),
      .shift      (shift),
      .op_onehot  (op_onehot),
      .cond_pass  (cond_pass),
      .out_valid  (out_valid),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // Reference decode: field extraction by plain arithmetic on the word value.
   function automatic exp_t model(input int w, input bit z, input bit n);
      exp_t m;
      m.c   = w / 16384;
      m.op  = (w / 1024) % 16;
      m.dst = (w / 128) % 8;
      m.s1  = (w / 16) % 8;
      m.s2  = (w / 2) % 8;
      m.sh  = w % 2;
      m.oh  = 2 ** m.op;
      case (m.c)
         0:       m.pass = 1;
         1:       m.pass = z ? 1 : 0;
         2:       m.pass = z ? 0 : 1;
         default: m.pass = n ? 1 : 0;
      endcase
      m.ill = (ILLEGAL_EN && m.op == 15) ? 1 : 0;
      if (m.ill == 1) m.pass = 0;
      return m;
   endfunction

   function automatic exp_t reset_exp();
      exp_t m;
      m.c = 0; m.op = 0; m.dst = 0; m.s1 = 0; m.s2 = 0; m.sh = 0;
      m.oh = 1; m.pass = 0; m.ill = 0;
      return m;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_fields(input string tag, input exp_t e);
      chk({tag, ".cond"},      int'(cond),      e.c);
      chk({tag, ".op_code"},   int'(op_code),   e.op);
      chk({tag, ".dest_reg"},  int'(dest_reg),  e.dst);
      chk({tag, ".src_reg_1"}, int'(src_reg_1), e.s1);
      chk({tag, ".src_reg_2"}, int'(src_reg_2), e.s2);
      chk({tag, ".shift"},     int'(shift),     e.sh);
      chk({tag, ".op_onehot"}, int'(op_onehot), e.oh);
      chk({tag, ".cond_pass"}, int'(cond_pass), e.pass);
      chk({tag, ".illegal"},   int'(illegal),   e.ill);
   endtask

   // Monitor: every presented output is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk_fields("decode", e);
         end
      end
   end

   task automatic send(input logic [15:0] w, input bit z, input bit n);
      exp_t e;
      inst       = w;
      inst_valid = 1'b1;
      flag_z     = z;
      flag_n     = n;
      e = model(int'(w), z, n);
      sb.push_back(e);
      last_exp = e;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         inst_valid = 1'b0;
         inst       = 16'($urandom);
         flag_z     = 1'($urandom);
         flag_n     = 1'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset(input string tag);
      chk_fields(tag, reset_exp());
      chk({tag, ".out_valid"}, int'(out_valid), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d, expected 0", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      inst       = 16'h0000;
      inst_valid = 1'b0;
      flag_z     = 1'b0;
      flag_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");

      rst = 1'b0;
      idle(2);
      chk("post_reset_out_valid", int'(out_valid), 0);

      // Directed cases.
      send(16'hAAAA, 1'b0, 1'b0);
      idle(1);
      send(16'hBBBB, 1'b1, 1'b1);
      send(16'hCCCC, 1'b1, 1'b1);

      // Hold: fields keep the 0xCCCC decode while inst_valid is low.
      inst       = 16'h1234;
      inst_valid = 1'b0;
      flag_z     = 1'b0;
      flag_n     = 1'b0;
      @(posedge clk);
      #1;
      chk_fields("hold", last_exp);
      chk("hold.out_valid", int'(out_valid), 0);
      idle(2);
      chk_fields("hold2", last_exp);

      // Reserved opcode, cond 0, plus its neighbours.
      send(16'h3C00, 1'b0, 1'b0);
      send(16'h3C01, 1'b1, 1'b0);
      send(16'hFFFF, 1'b0, 1'b1);
      send(16'h0000, 1'b1, 1'b1);
      idle(1);

      // Randomized traffic with random gaps.
      for (int i = 0; i < 300; i++) begin
         send(16'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
      end
      idle(1);

      // Reset collides with a valid instruction: reset wins.
      rst        = 1'b1;
      inst       = 16'hAAAA;
      inst_valid = 1'b1;
      flag_z     = 1'b0;
      flag_n     = 1'b0;
      @(posedge clk);
      #1;
      check_reset("reset_collision");
      rst        = 1'b0;
      inst_valid = 1'b0;
      idle(2);
      chk("collision_out_valid", int'(out_valid), 0);

      // Stream resumes cleanly after reset.
      send(16'h5A5A, 1'b1, 1'b0);
      send(16'h8421, 1'b0, 1'b1);
      idle(3);

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
